// File: rtl/cic_rate_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cic_rate_ctrl_if                                     |
// | Description : Configuration handshake bundle for cic_rate_ctrl.    |
// |               The master requests a new decimation ratio and the   |
// |               slave accepts it or flags it as illegal.             |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
interface cic_rate_ctrl_if;
  logic       cfg_valid;
  logic [4:0] cfg_r;
  logic       cfg_ready;
  logic       cfg_err;

  modport master (output cfg_valid, output cfg_r, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_r, output cfg_ready, output cfg_err);
endinterface
`default_nettype wire

// File: rtl/cic_rate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cic_rate_ctrl                                        |
// | Description : Run-time decimation-ratio controller for a CIC       |
// |               decimator. Accepts ratio changes, rejects illegal    |
// |               ratios, drains/flushes/settles the filter on change  |
// |               and strobes out_valid once per output period.        |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module cic_rate_ctrl #(
  parameter logic [4:0] DEFAULT_R      = 5'd1,
  parameter int         CLK_PER_SAMPLE = 3,
  parameter int         FLUSH_CYCLES   = 2,
  parameter int         SETTLE_PERIODS = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  cic_rate_ctrl_if.slave cfg,
  output logic [4:0]     cic_r_o,
  output logic           cic_rst_n_o,
  output logic           out_valid_o,
  output logic           busy_o
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam logic [7:0] C_CPS        = 8'(CLK_PER_SAMPLE);
  localparam logic [7:0] C_FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  // Output period in clocks: one input sample time scaled by the ratio.
  function automatic logic [7:0] period_of(input logic [4:0] r);
    case (r)
      5'd2:    return C_CPS << 1;
      5'd4:    return C_CPS << 2;
      5'd8:    return C_CPS << 3;
      5'd16:   return C_CPS << 4;
      default: return C_CPS;
    endcase
  endfunction

  function automatic logic is_legal(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd2) || (r == 5'd4) || (r == 5'd8) || (r == 5'd16);
  endfunction

  logic [1:0] state_q,     state_d;
  logic [7:0] cnt_q,       cnt_d;
  logic [4:0] cic_r_q,     cic_r_d;
  logic [4:0] pend_r_q,    pend_r_d;
  logic       cic_rst_n_q, cic_rst_n_d;
  logic       cfg_err_q,   cfg_err_d;

  logic [7:0] w_period;
  logic [7:0] w_settle_len;
  logic       w_last;
  logic       w_hs;

  // cic_r only changes at the DRAIN->FLUSH boundary, so SETTLE already
  // measures its length in periods of the new ratio.
  assign w_period     = period_of(cic_r_q);
  assign w_settle_len = 8'(SETTLE_PERIODS * int'(w_period));
  assign w_last       = (cnt_q == w_period - 8'd1);
  assign w_hs         = cfg.cfg_valid && (state_q == S_RUN);

  assign cfg.cfg_ready = (state_q == S_RUN);
  assign cfg.cfg_err   = cfg_err_q;
  assign cic_r_o       = cic_r_q;
  assign cic_rst_n_o   = cic_rst_n_q;
  assign busy_o        = (state_q != S_RUN);
  assign out_valid_o   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && w_last;

  // Next-state logic: phase counting, request decode and change sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cic_r_d     = cic_r_q;
    pend_r_d    = pend_r_q;
    cic_rst_n_d = cic_rst_n_q;
    cfg_err_d   = 1'b0;
    case (state_q)
      S_RUN: begin
        cnt_d = w_last ? 8'd0 : cnt_q + 8'd1;
        if (w_hs) begin
          if (is_legal(cfg.cfg_r)) begin
            // A request landing on the last phase lets that strobe out and
            // then drains one full extra period.
            pend_r_d = cfg.cfg_r;
            state_d  = S_DRAIN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cnt_d = w_last ? 8'd0 : cnt_q + 8'd1;
        if (w_last) begin
          state_d     = S_FLUSH;
          cnt_d       = 8'd0;
          cic_r_d     = pend_r_q;
          cic_rst_n_d = 1'b0;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == C_FLUSH_LAST) begin
          state_d     = S_SETTLE;
          cnt_d       = 8'd0;
          cic_rst_n_d = 1'b1;
        end
      end
      default: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == w_settle_len - 8'd1) begin
          state_d = S_RUN;
          cnt_d   = 8'd0;
        end
      end
    endcase
  end

  // State registers; reset restores the default ratio and discards any pending one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SETTLE;
      cnt_q       <= 8'd0;
      cic_r_q     <= DEFAULT_R;
      pend_r_q    <= DEFAULT_R;
      cic_rst_n_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cic_r_q     <= cic_r_d;
      pend_r_q    <= pend_r_d;
      cic_rst_n_q <= cic_rst_n_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule
`default_nettype wire
